// File: rtl/aes_key_expander_seq.sv
// Iterative AES-128/192/256 key schedule: one expanded word per clock into a 60x32 round-key table.
// Latency: 40/46/52 cycles from the accepted start to done; rk_rd_data follows rk_rd_idx by one cycle.
// Backpressure: none; start is only sampled while idle, so a start during expansion is dropped.
module aes_key_expander_seq #(
    parameter int ENABLE_192 = 1,
    parameter int ENABLE_256 = 1,
    parameter int IDX_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        key_len,
    input  logic [255:0]      key_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rk_valid,
    input  logic [IDX_W-1:0]  rk_rd_idx,
    output logic [127:0]      rk_rd_data
);

    // FIPS-197 S-box, entry x at bits [8*(255-x) +: 8]
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    typedef enum logic {IDLE, EXPAND} state_t;

    state_t             state_q, state_d;
    logic [31:0]        ram [0:59];
    logic [5:0]         i_q;
    logic [2:0]         j_q;
    logic [7:0]         rcon_q;
    logic [3:0]         nk_q;
    logic [IDX_W-1:0]   nr_q;
    logic [5:0]         last_q;

    logic               supported;
    logic [3:0]         nk_new;
    logic [IDX_W-1:0]   nr_new;
    logic [5:0]         last_new;
    logic               accept, reject, expand_en, j_wrap;
    logic [31:0]        prev_w, back_w, sub_in, sub_out, temp_w, new_w;
    logic [5:0]         rd_base;

    // Mode decode for the key length presented with start
    always_comb begin
        supported = 1'b0;
        nk_new    = 4'd4;
        nr_new    = IDX_W'(10);
        last_new  = 6'd43;
        case (key_len)
            2'b00: supported = 1'b1;
            2'b01: begin
                supported = (ENABLE_192 != 0);
                nk_new    = 4'd6;
                nr_new    = IDX_W'(12);
                last_new  = 6'd51;
            end
            2'b10: begin
                supported = (ENABLE_256 != 0);
                nk_new    = 4'd8;
                nr_new    = IDX_W'(14);
                last_new  = 6'd59;
            end
            default: supported = 1'b0;
        endcase
    end

    assign accept    = (state_q == IDLE) && start && supported;
    assign reject    = (state_q == IDLE) && start && !supported;
    assign expand_en = (state_q == EXPAND);
    assign j_wrap    = ({1'b0, j_q} == (nk_q - 4'd1));

    // One key-schedule step: the shared S-box sees RotWord(prev) at j==0 and prev otherwise
    always_comb begin
        prev_w  = ram[i_q - 6'd1];
        back_w  = ram[i_q - {2'b00, nk_q}];
        sub_in  = (j_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
        sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
        temp_w  = prev_w;
        if (j_q == 3'd0)
            temp_w = sub_out ^ {rcon_q, 24'h0};
        else if ((nk_q == 4'd8) && (j_q == 3'd4))
            temp_w = sub_out;
        new_w = back_w ^ temp_w;
    end

    // Next-state: run until the last word of the latched mode is written
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXPAND;
            EXPAND:  if (i_q == last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Control, counters and status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            rk_valid <= 1'b0;
            rcon_q   <= 8'h01;
            i_q      <= 6'd0;
            j_q      <= 3'd0;
            nk_q     <= 4'd4;
            nr_q     <= IDX_W'(10);
            last_q   <= 6'd43;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (accept) begin
                nk_q     <= nk_new;
                nr_q     <= nr_new;
                last_q   <= last_new;
                i_q      <= {2'b00, nk_new};
                j_q      <= 3'd0;
                rcon_q   <= 8'h01;
                busy     <= 1'b1;
                rk_valid <= 1'b0;
            end else if (reject) begin
                err <= 1'b1;
            end
            if (expand_en) begin
                i_q <= i_q + 6'd1;
                j_q <= j_wrap ? 3'd0 : j_q + 3'd1;
                if (j_q == 3'd0)
                    rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                if (i_q == last_q) begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    rk_valid <= 1'b1;
                end
            end
        end
    end

    // Round-key table writes: key words on accept, one generated word per expand cycle
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < 8; k++) begin
                if (k[3:0] < nk_new)
                    ram[k[5:0]] <= key_in[(8'd255 - {k[2:0], 5'd0}) -: 32];
            end
        end
        if (expand_en)
            ram[i_q] <= new_w;
    end

    assign rd_base = {rk_rd_idx[3:0], 2'b00};

    // Registered round-key read; indices beyond Nr of the latched mode read as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rk_rd_data <= 128'h0;
        else if (rk_rd_idx > nr_q)
            rk_rd_data <= 128'h0;
        else
            rk_rd_data <= {ram[rd_base], ram[rd_base + 6'd1], ram[rd_base + 6'd2], ram[rd_base + 6'd3]};
    end

endmodule

// File: tb/tb_aes_key_expander_seq.sv
module tb_aes_key_expander_seq;

    localparam logic [1:0] EV_DONE = 2'd0;
    localparam logic [1:0] EV_ERR  = 2'd1;
    localparam logic [1:0] EV_ERR2 = 2'd2;
    localparam logic [1:0] EV_RD   = 2'd3;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hffffffffffffffffffffffffffffffff};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hdeadbeefcafef00d};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    typedef struct packed {
        logic [1:0]   kind;
        logic [7:0]   tag;
        logic [127:0] val;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start, start2;
    logic [1:0]     key_len, key_len2;
    logic [255:0]   key_in;
    logic [3:0]     rk_rd_idx;
    logic           busy, done, err, rk_valid;
    logic [127:0]   rk_rd_data;
    logic           busy2, done2, err2, rk_valid2;
    logic [127:0]   rk_rd_data2;
    logic           rd_req, rd_vld;
    int             cyc = 0;
    int             checks = 0;
    int             errors = 0;
    exp_t           sb[$];

    always #5 clk = ~clk;

    aes_key_expander_seq #(.ENABLE_192(1), .ENABLE_256(1), .IDX_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key_in(key_in),
        .busy(busy), .done(done), .err(err), .rk_valid(rk_valid),
        .rk_rd_idx(rk_rd_idx), .rk_rd_data(rk_rd_data)
    );

    aes_key_expander_seq #(.ENABLE_192(0), .ENABLE_256(1), .IDX_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .key_len(key_len2), .key_in(key_in),
        .busy(busy2), .done(done2), .err(err2), .rk_valid(rk_valid2),
        .rk_rd_idx(rk_rd_idx), .rk_rd_data(rk_rd_data2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_vld <= 1'b0;
        else        rd_vld <= rd_req;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic push_ev(input logic [1:0] kind, input logic [7:0] tag, input logic [127:0] val);
        exp_t e;
        e.kind = kind;
        e.tag  = tag;
        e.val  = val;
        sb.push_back(e);
    endtask

    function automatic string ev_name(input logic [1:0] kind);
        case (kind)
            EV_DONE: return "done_cycle";
            EV_ERR:  return "err_cycle";
            EV_ERR2: return "err2_cycle";
            default: return "rd_data";
        endcase
    endfunction

    task automatic pop_cmp(input logic [1:0] kind, input logic [127:0] act);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: got %h expected no event", ev_name(kind), act);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind) begin
                errors++;
                $display("FAIL event_order: got %s expected %s", ev_name(kind), ev_name(e.kind));
            end else if (e.val !== act) begin
                errors++;
                $display("FAIL %s tag=%0d: got %h expected %h", ev_name(kind), e.tag, act, e.val);
            end
        end
    endtask

    // Monitor: every DUT event is matched against the next queued expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (done)   pop_cmp(EV_DONE, 128'(cyc));
            if (err)    pop_cmp(EV_ERR,  128'(cyc));
            if (err2)   pop_cmp(EV_ERR2, 128'(cyc));
            if (rd_vld) pop_cmp(EV_RD,   rk_rd_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [1:0] kl, input logic [255:0] k, input int lat, input bit expect_done);
        start   = 1'b1;
        key_len = kl;
        key_in  = k;
        tick();
        start   = 1'b0;
        if (expect_done) push_ev(EV_DONE, 8'(lat), 128'(cyc + lat));
        chk("busy_after_start", 128'(busy), 128'd1);
        chk("rk_valid_after_start", 128'(rk_valid), 128'd0);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 128'(done), 128'd1);
        chk("rk_valid_at_done", 128'(rk_valid), 128'd1);
        chk("busy_at_done", 128'(busy), 128'd0);
    endtask

    task automatic rd(input logic [3:0] idx, input logic [127:0] exp_val);
        rk_rd_idx = idx;
        rd_req    = 1'b1;
        push_ev(EV_RD, 8'(idx), exp_val);
        tick();
        rd_req    = 1'b0;
    endtask

    task automatic check_aes128_reads();
        rd(4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c);
        rd(4'd1,  128'ha0fafe1788542cb123a339392a6c7605);
        rd(4'd2,  128'hf2c295f27a96b9435935807a7359f67f);
        rd(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd(4'd11, 128'h0);
        rd(4'd14, 128'h0);
        tick();
    endtask

    initial begin
        logic rkv_before;
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; key_len = 2'b00; key_len2 = 2'b00;
        key_in = 256'h0; rk_rd_idx = 4'd0; rd_req = 1'b0;
        #1;
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_done", 128'(done), 128'd0);
        chk("reset_err", 128'(err), 128'd0);
        chk("reset_rk_valid", 128'(rk_valid), 128'd0);
        chk("reset_rd_data", rk_rd_data, 128'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // AES-128
        start_run(2'b00, K128, 40, 1'b1);
        wait_done(60);
        tick();
        check_aes128_reads();

        // AES-192
        start_run(2'b01, K192, 46, 1'b1);
        wait_done(70);
        tick();
        rd(4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5);
        rd(4'd1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5);
        rd(4'd12, 128'he98ba06f448c773c8ecc720401002202);
        rd(4'd13, 128'h0);
        tick();

        // AES-256
        start_run(2'b10, K256, 52, 1'b1);
        wait_done(80);
        tick();
        rd(4'd0,  128'h603deb1015ca71be2b73aef0857d7781);
        rd(4'd1,  128'h1f352c073b6108d72d9810a30914dff4);
        rd(4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde);
        rd(4'd14, 128'hfe4890d1e6188d0b046df344706c631e);
        rd(4'd15, 128'h0);
        tick();

        // Reserved key length: err pulse only
        rkv_before = rk_valid;
        start = 1'b1; key_len = 2'b11;
        tick();
        start = 1'b0;
        push_ev(EV_ERR, 8'd0, 128'(cyc));
        chk("err_busy_low", 128'(busy), 128'd0);
        chk("err_rk_valid_kept", 128'(rk_valid), 128'(rkv_before));
        tick();
        chk("err_one_cycle", 128'(err), 128'd0);
        rd(4'd14, 128'hfe4890d1e6188d0b046df344706c631e);

        // AES-192 disabled instance
        start2 = 1'b1; key_len2 = 2'b01;
        tick();
        start2 = 1'b0;
        push_ev(EV_ERR2, 8'd1, 128'(cyc));
        chk("err2_busy_low", 128'(busy2), 128'd0);
        chk("err2_rk_valid_kept", 128'(rk_valid2), 128'd0);
        tick();
        chk("err2_one_cycle", 128'(err2), 128'd0);

        // Abort: AES-256 run, ignored start, reset mid-expansion
        start_run(2'b10, K256, 52, 1'b0);
        repeat (9) tick();
        start = 1'b1; key_len = 2'b00;
        tick();
        start = 1'b0;
        chk("busy_ignored_start", 128'(busy), 128'd1);
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_done", 128'(done), 128'd0);
        chk("abort_err", 128'(err), 128'd0);
        chk("abort_rk_valid", 128'(rk_valid), 128'd0);
        chk("abort_rd_data", rk_rd_data, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start_run(2'b00, K128, 40, 1'b1);
        wait_done(60);
        tick();
        check_aes128_reads();

        // Back-to-back: AES-128 then AES-256 started on the done cycle
        start_run(2'b00, K128, 40, 1'b1);
        wait_done(60);
        start = 1'b1; key_len = 2'b10; key_in = K256;
        tick();
        start = 1'b0;
        push_ev(EV_DONE, 8'd52, 128'(cyc + 52));
        chk("b2b_rk_valid_cleared", 128'(rk_valid), 128'd0);
        chk("b2b_busy", 128'(busy), 128'd1);
        repeat (9) tick();
        start = 1'b1; key_len = 2'b00; key_in = K128;
        tick();
        start = 1'b0;
        wait_done(80);
        tick();
        rd(4'd14, 128'hfe4890d1e6188d0b046df344706c631e);
        rd(4'd0,  128'h603deb1015ca71be2b73aef0857d7781);
        repeat (3) tick();

        chk("scoreboard_drained", 128'(sb.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
